// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA raster generator.
package vga_timing_pkg;

   localparam int unsigned CNT_W     = 10;
   localparam int unsigned MAX_TOTAL = 1 << CNT_W;

   // 640x480@60 defaults
   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;

   typedef enum logic [1:0] {
      PH_VISIBLE = 2'd0,
      PH_FRONT   = 2'd1,
      PH_SYNC    = 2'd2,
      PH_BACK    = 2'd3
   } axis_phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus VISIBLE/FRONT/SYNC/BACK phase FSM.
// count_c_o/phase_c_o expose the post-step values so the top can register outputs on the same edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned VISIBLE = H_VISIBLE_DEF,
   parameter int unsigned FRONT   = H_FRONT_DEF,
   parameter int unsigned SYNC    = H_SYNC_DEF,
   parameter int unsigned BACK    = H_BACK_DEF
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   input  logic             step_i,
   output logic [CNT_W-1:0] count_c_o,
   output axis_phase_e      phase_c_o,
   output logic             wrap_c_o
);

   localparam int unsigned TOTAL = VISIBLE + FRONT + SYNC + BACK;

   if (VISIBLE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1 || TOTAL > MAX_TOTAL) begin : g_bad_params
      $error("vga_axis_counter: phase widths must be >= 1 and total <= %0d", MAX_TOTAL);
   end

   localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] END_VIS   = CNT_W'(VISIBLE - 1);
   localparam logic [CNT_W-1:0] END_FRONT = CNT_W'(VISIBLE + FRONT - 1);
   localparam logic [CNT_W-1:0] END_SYNC  = CNT_W'(VISIBLE + FRONT + SYNC - 1);

   logic [CNT_W-1:0] count_q, count_d;
   axis_phase_e      phase_q, phase_d;
   logic             wrap_c;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= LAST;
         phase_q <= PH_BACK;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
      end
   end

   // Phase advances on the step that leaves the last count of the current phase.
   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      wrap_c  = 1'b0;
      if (step_i) begin
         wrap_c  = (count_q == LAST);
         count_d = wrap_c ? '0 : count_q + CNT_W'(1);
         case (phase_q)
            PH_VISIBLE: if (count_q == END_VIS)   phase_d = PH_FRONT;
            PH_FRONT:   if (count_q == END_FRONT) phase_d = PH_SYNC;
            PH_SYNC:    if (count_q == END_SYNC)  phase_d = PH_BACK;
            PH_BACK:    if (wrap_c)               phase_d = PH_VISIBLE;
            default:                              phase_d = PH_BACK;
         endcase
      end
   end

   assign count_c_o = count_d;
   assign phase_c_o = phase_d;
   assign wrap_c_o  = wrap_c;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY, blank, hs/vs and line/frame start pulses, all
// registered from the same counter step so they stay mutually aligned.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE       = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT         = H_FRONT_DEF,
   parameter int unsigned H_SYNC          = H_SYNC_DEF,
   parameter int unsigned H_BACK          = H_BACK_DEF,
   parameter int unsigned V_VISIBLE       = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT         = V_FRONT_DEF,
   parameter int unsigned V_SYNC          = V_SYNC_DEF,
   parameter int unsigned V_BACK          = V_BACK_DEF,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   input  logic             en,
   output logic [CNT_W-1:0] DrawX,
   output logic [CNT_W-1:0] DrawY,
   output logic             blank,
   output logic             hs,
   output logic             vs,
   output logic             line_start,
   output logic             frame_start
);

   localparam logic SYNC_ACT = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

   logic [CNT_W-1:0] h_cnt_nxt, v_cnt_nxt;
   axis_phase_e      h_ph_nxt, v_ph_nxt;
   logic             h_wrap, v_wrap;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .vga_clk   (vga_clk),
      .reset_n   (reset_n),
      .step_i    (en),
      .count_c_o (h_cnt_nxt),
      .phase_c_o (h_ph_nxt),
      .wrap_c_o  (h_wrap)
   );

   // Vertical axis only advances when the horizontal axis wraps on an enabled cycle.
   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .vga_clk   (vga_clk),
      .reset_n   (reset_n),
      .step_i    (h_wrap),
      .count_c_o (v_cnt_nxt),
      .phase_c_o (v_ph_nxt),
      .wrap_c_o  (v_wrap)
   );

   logic [CNT_W-1:0] draw_x_q, draw_x_d, draw_y_q, draw_y_d;
   logic             blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
   logic             line_start_q, line_start_d, frame_start_q, frame_start_d;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         draw_x_q      <= '0;
         draw_y_q      <= '0;
         blank_q       <= 1'b0;
         hs_q          <= ~SYNC_ACT;
         vs_q          <= ~SYNC_ACT;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         draw_x_q      <= draw_x_d;
         draw_y_q      <= draw_y_d;
         blank_q       <= blank_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   always_comb begin
      draw_x_d      = draw_x_q;
      draw_y_d      = draw_y_q;
      blank_d       = blank_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (en) begin
         draw_x_d      = h_cnt_nxt;
         draw_y_d      = v_cnt_nxt;
         blank_d       = (h_ph_nxt == PH_VISIBLE) && (v_ph_nxt == PH_VISIBLE);
         hs_d          = (h_ph_nxt == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
         vs_d          = (v_ph_nxt == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
         line_start_d  = h_wrap;
         frame_start_d = v_wrap;
      end
   end

   assign DrawX       = draw_x_q;
   assign DrawY       = draw_y_q;
   assign blank       = blank_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for reset/line/async-reset checks, and a
// tiny active-high-sync instance for full-frame and enable-gating checks.
module tb_vga_timing_gen;

   // Tiny raster for the second instance: 15 x 11, frame of 165 pixels
   localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2, SHT = 15;
   localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 2, SVT = 11;

   logic       clk;
   logic       rst_n_a, en_a, rst_n_s, en_s;
   logic [9:0] x_a, y_a, x_s, y_s;
   logic       blank_a, hs_a, vs_a, ls_a, fs_a;
   logic       blank_s, hs_s, vs_s, ls_s, fs_s;
   logic [24:0] obs_a, obs_s, exp_v;

   int vectors = 0;
   int miscompares = 0;
   int ax, ay, sx, sy;

   vga_timing_gen dut (
      .vga_clk     (clk),
      .reset_n     (rst_n_a),
      .en          (en_a),
      .DrawX       (x_a),
      .DrawY       (y_a),
      .blank       (blank_a),
      .hs          (hs_a),
      .vs          (vs_a),
      .line_start  (ls_a),
      .frame_start (fs_a)
   );

   vga_timing_gen #(
      .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
      .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
      .SYNC_ACTIVE_LOW (1'b0)
   ) dut_s (
      .vga_clk     (clk),
      .reset_n     (rst_n_s),
      .en          (en_s),
      .DrawX       (x_s),
      .DrawY       (y_s),
      .blank       (blank_s),
      .hs          (hs_s),
      .vs          (vs_s),
      .line_start  (ls_s),
      .frame_start (fs_s)
   );

   assign obs_a = {x_a, y_a, blank_a, hs_a, vs_a, ls_a, fs_a};
   assign obs_s = {x_s, y_s, blank_s, hs_s, vs_s, ls_s, fs_s};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {x, y, blank, hs, vs, line_start, frame_start} for a position.
   function automatic logic [24:0] model_vec(input int x, input int y, input bit ls, input bit fs,
                                             input int hv, input int hf, input int hsw,
                                             input int vv, input int vf, input int vsw,
                                             input bit act_low);
      bit bl, h_act, v_act, hsv, vsv;
      bl    = (x < hv) && (y < vv);
      h_act = (x >= hv + hf) && (x < hv + hf + hsw);
      v_act = (y >= vv + vf) && (y < vv + vf + vsw);
      hsv   = h_act ? ~act_low : act_low;
      vsv   = v_act ? ~act_low : act_low;
      return {10'(x), 10'(y), bl, hsv, vsv, ls, fs};
   endfunction

   task automatic test_reset;
      rst_n_a = 1'b0; rst_n_s = 1'b0; en_a = 1'b1; en_s = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (obs_a !== 25'b0000000000_0000000000_0_1_1_0_0) begin
         miscompares++;
         $display("FAIL reset_default: got %h expected %h", obs_a, 25'b0000000000_0000000000_0_1_1_0_0);
      end
      vectors++;
      if (obs_s !== 25'd0) begin
         miscompares++;
         $display("FAIL reset_active_high_sync: got %h expected %h", obs_s, 25'd0);
      end
   endtask

   task automatic test_first_cycle;
      rst_n_a = 1'b1;
      @(negedge clk);
      ax = 0; ay = 0;
      exp_v = model_vec(0, 0, 1'b1, 1'b1, 640, 16, 96, 480, 10, 2, 1'b1);
      vectors++;
      if (obs_a !== exp_v) begin
         miscompares++;
         $display("FAIL first_cycle: got %h expected %h", obs_a, exp_v);
      end
   endtask

   task automatic test_line_timing;
      int hs_low = 0, blank_lo = 0, ls_cnt = 0, ls_prev = 0, ls_period = 0;
      for (int i = 1; i <= 2400; i++) begin
         @(negedge clk);
         ax = (ax == 799) ? 0 : ax + 1;
         if (ax == 0) ay = ay + 1;
         exp_v = model_vec(ax, ay, ax == 0, (ax == 0) && (ay == 0), 640, 16, 96, 480, 10, 2, 1'b1);
         vectors++;
         if (obs_a !== exp_v) begin
            miscompares++;
            $display("FAIL line_pixel x=%0d y=%0d: got %h expected %h", ax, ay, obs_a, exp_v);
         end
         if (ay == 0 && hs_a === 1'b0) hs_low++;
         if (ay == 1 && blank_a === 1'b0) blank_lo++;
         if (ls_a === 1'b1) begin
            ls_cnt++;
            ls_period = i - ls_prev;
            ls_prev = i;
         end
      end
      vectors++;
      if (hs_low !== 96) begin
         miscompares++;
         $display("FAIL hs_width: got %0d expected 96", hs_low);
      end
      vectors++;
      if (blank_lo !== 160) begin
         miscompares++;
         $display("FAIL h_blank_width: got %0d expected 160", blank_lo);
      end
      vectors++;
      if (ls_cnt !== 3 || ls_period !== 800) begin
         miscompares++;
         $display("FAIL line_start_period: got count %0d period %0d expected 3 / 800", ls_cnt, ls_period);
      end
   endtask

   task automatic test_async_reset;
      repeat (300) @(negedge clk);
      vectors++;
      if (x_a !== 10'd300 || y_a !== 10'd3) begin
         miscompares++;
         $display("FAIL pre_reset_pos: got (%0d,%0d) expected (300,3)", x_a, y_a);
      end
      #2 rst_n_a = 1'b0;
      #1;
      vectors++;
      if (obs_a !== 25'b0000000000_0000000000_0_1_1_0_0) begin
         miscompares++;
         $display("FAIL async_reset: got %h expected %h", obs_a, 25'b0000000000_0000000000_0_1_1_0_0);
      end
      repeat (2) @(negedge clk);
      rst_n_a = 1'b1;
      @(negedge clk);
      exp_v = model_vec(0, 0, 1'b1, 1'b1, 640, 16, 96, 480, 10, 2, 1'b1);
      vectors++;
      if (obs_a !== exp_v) begin
         miscompares++;
         $display("FAIL after_reset_first: got %h expected %h", obs_a, exp_v);
      end
      @(negedge clk);
      exp_v = model_vec(1, 0, 1'b0, 1'b0, 640, 16, 96, 480, 10, 2, 1'b1);
      vectors++;
      if (obs_a !== exp_v) begin
         miscompares++;
         $display("FAIL after_reset_second: got %h expected %h", obs_a, exp_v);
      end
   endtask

   task automatic test_frame_timing;
      int fs_cnt = 0, fs_prev = 0, fs_period = 0, vs_hi = 0, bl_hi = 0;
      rst_n_s = 1'b1; en_s = 1'b1;
      sx = SHT - 1; sy = SVT - 1;
      for (int i = 1; i <= 2 * SHT * SVT; i++) begin
         @(negedge clk);
         sx = (sx == SHT - 1) ? 0 : sx + 1;
         if (sx == 0) sy = (sy == SVT - 1) ? 0 : sy + 1;
         exp_v = model_vec(sx, sy, sx == 0, (sx == 0) && (sy == 0), SHV, SHF, SHS, SVV, SVF, SVS, 1'b0);
         vectors++;
         if (obs_s !== exp_v) begin
            miscompares++;
            $display("FAIL frame_pixel x=%0d y=%0d: got %h expected %h", sx, sy, obs_s, exp_v);
         end
         if (i <= SHT * SVT && vs_s === 1'b1) vs_hi++;
         if (i <= SHT * SVT && blank_s === 1'b1) bl_hi++;
         if (fs_s === 1'b1) begin
            fs_cnt++;
            fs_period = i - fs_prev;
            fs_prev = i;
         end
      end
      vectors++;
      if (vs_hi !== 30) begin
         miscompares++;
         $display("FAIL vs_width: got %0d expected 30", vs_hi);
      end
      vectors++;
      if (bl_hi !== 48) begin
         miscompares++;
         $display("FAIL active_pixels: got %0d expected 48", bl_hi);
      end
      vectors++;
      if (fs_cnt !== 2 || fs_period !== 165) begin
         miscompares++;
         $display("FAIL frame_start_period: got count %0d period %0d expected 2 / 165", fs_cnt, fs_period);
      end
   endtask

   task automatic test_en_alternate;
      int fs_cnt = 0, fs_prev = 0, fs_period = 0;
      bit stepped;
      for (int i = 0; i < 4 * SHT * SVT; i++) begin
         stepped = (i % 2 == 0);
         en_s = stepped;
         @(negedge clk);
         if (stepped) begin
            sx = (sx == SHT - 1) ? 0 : sx + 1;
            if (sx == 0) sy = (sy == SVT - 1) ? 0 : sy + 1;
         end
         exp_v = model_vec(sx, sy, stepped && sx == 0, stepped && sx == 0 && sy == 0,
                           SHV, SHF, SHS, SVV, SVF, SVS, 1'b0);
         vectors++;
         if (obs_s !== exp_v) begin
            miscompares++;
            $display("FAIL en_alt i=%0d x=%0d y=%0d: got %h expected %h", i, sx, sy, obs_s, exp_v);
         end
         if (fs_s === 1'b1) begin
            fs_cnt++;
            fs_period = i - fs_prev;
            fs_prev = i;
         end
      end
      vectors++;
      if (fs_cnt !== 2 || fs_period !== 330) begin
         miscompares++;
         $display("FAIL en_alt_frame_period: got count %0d period %0d expected 2 / 330", fs_cnt, fs_period);
      end
      en_s = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_cycle();
      test_line_timing();
      test_async_reset();
      test_frame_timing();
      test_en_alternate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
